inst_fetch_buffer: RTL
======================

# inst_fetch_buffer

Instruction fetch buffer between the PC generator and decode. Takes fetch addresses through a valid/ready handshake and issues them to instruction memory over a req/gnt/rvalid protocol, with up to DEPTH requests in flight. Returned instructions are kept in order, together with their PC and PC+4, and are presented to decode through valid/ready. A redirect flush empties the buffer and discards responses that are still in flight, so a taken branch never delivers stale instructions.

## Interface
- XLEN, 32, address/PC width.
- DEPTH, 4, number of buffer entries and the maximum number of memory requests in flight; power of two, ≥2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- f_valid  in  1  fetch presents an address.
- f_pc  in  XLEN  fetch address; bits [1:0] are ignored and forced to 0 on imem_addr.
- f_ready  out  1  address accepted this cycle (= imem_req & imem_gnt).
- flush  in  1  redirect; discards all buffered and in-flight instructions.
- imem_req  out  1  memory request.
- imem_addr  out  XLEN  request address ({f_pc[XLEN-1:2], 2'b00}).
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response valid; responses return in request order.
- imem_rdata  in  32  instruction word.
- d_valid  out  1  head entry is filled.
- d_inst  out  32  head instruction.
- d_pc  out  XLEN  head PC.
- d_pc_pls4  out  XLEN  d_pc + 4, modulo 2^XLEN.
- d_ready  in  1  decode consumes the head entry.

## Operation
- **Entries.** Each entry holds {pc, inst, filled}.
  - Three pointers of log2(DEPTH)+1 bits each: alloc, fill, read.
  - outstanding = alloc − fill.
  - drop_cnt counts responses still owed for flushed requests; range 0..DEPTH.
- **Request.** imem_req = f_valid & !flush & ((alloc − read) + drop_cnt < DEPTH).
  - This is purely combinational from the inputs and state.
- **Allocation (imem_req & imem_gnt).** Write f_pc into entry[alloc], clear its filled bit, then increment alloc.
- **Response (imem_rvalid).**
  - If drop_cnt > 0: discard the data and decrement drop_cnt.
  - Otherwise: write imem_rdata into entry[fill], set filled, increment fill.
- **Pop.** d_valid & d_ready: increment read.
  - d_valid = (read != fill).
- **Flush.** On a flush cycle:
  - Set alloc = fill = read (the buffer becomes empty).
  - drop_cnt_next = drop_cnt + outstanding − (imem_rvalid ? 1 : 0).
  - A pop in the same cycle is ignored.
  - No request is issued that cycle.
- **Protocol violation.** imem_rvalid with drop_cnt = 0 and outstanding = 0 is ignored and changes no state.
- **Output path.** d_inst, d_pc and d_pc_pls4 are read combinationally from entry[read]. When d_valid = 0 their values are don't-care.

## Timing
- **Reset.** While rst is high, and on the first edge after it deasserts:
  - Pointers = 0, drop_cnt = 0, all storage = 0.
  - d_valid = 0, imem_req = 0 unless f_valid, d_pc = 0, d_pc_pls4 = 4, d_inst = 0.
- **Reset mid-operation.** Asserting rst drops everything immediately, including in-flight requests. The memory must also be reset; a later stale imem_rvalid is a violation.
- **Response timing.** A response may arrive at the earliest in the cycle after its grant.
- **Latency.** imem_rvalid in cycle N gives d_valid = 1 in cycle N+1 (one register stage).
- **Throughput.** One instruction per cycle sustained when memory latency ≤ DEPTH−1 cycles and d_ready stays high.
- **Full.** When (alloc − read) + drop_cnt = DEPTH: imem_req = 0 and f_ready = 0 until a pop or a discarded response frees a slot. A slot freed in cycle N allows a request in cycle N+1.
- **Empty.** d_valid = 0 while entries are allocated but unfilled; read never passes fill.
- **Pointer wrap.** Pointers wrap modulo 2·DEPTH. The MSB distinguishes full from empty.

## Test plan
- **Reset and single fetch.**
  - Stimulus: after rst, f_pc = 0x0000_0100 with gnt = 1; rvalid one cycle later with rdata = 0x0000_0013; d_ready = 1.
  - Required: d_valid = 1 one cycle after rvalid, with d_pc = 0x100, d_pc_pls4 = 0x104, d_inst = 0x13.
- **Streaming with wrap.**
  - Stimulus: 3-cycle memory latency, 12 sequential PCs from 0x0, d_ready = 1.
  - Required: all 12 delivered in order.
  - Required: no bubbles after the first is delivered.
  - Required: pointers wrap at least once.
- **Full back-pressure.**
  - Stimulus: d_ready = 0, immediate responses.
  - Required: after DEPTH = 4 grants, imem_req = 0 and f_ready = 0.
  - Stimulus: one pop.
  - Required: exactly one more request is issued the next cycle.
- **Flush with in-flight requests.**
  - Stimulus: 2 requests in flight plus 1 filled entry; assert flush; then redirect to 0x200.
  - Required: d_valid = 0 the next cycle.
  - Required: the two old responses are discarded (drop_cnt 2→0).
  - Required: the instruction for 0x200 is delivered first.
- **Flush coinciding with response and pop.**
  - Stimulus: flush, imem_rvalid and d_ready all high in the same cycle, with outstanding = 1.
  - Required: drop_cnt stays 0.
  - Required: no stale instruction appears.
  - Required: buffer empty, imem_req = 0 that cycle.
- **Asynchronous reset mid-stream.**
  - Stimulus: rst asserted between clock edges while 3 entries are occupied.
  - Required: d_valid = 0 and d_pc = 0 immediately.
  - Required: normal fetch resumes after deassertion.

Source files
------------

// File: rtl/inst_fetch_buffer_if.sv
// Bundle of the three handshakes around the instruction fetch buffer:
// fetch address in (valid/ready), instruction memory (req/gnt/rvalid)
// and decode out (valid/ready), plus the redirect flush.
// master = environment side (fetch unit, memory, decode), slave = the buffer.
interface inst_fetch_buffer_if #(
  parameter int XLEN = 32
);
  logic            f_valid;
  logic [XLEN-1:0] f_pc;
  logic            f_ready;
  logic            flush;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            d_valid;
  logic [31:0]     d_inst;
  logic [XLEN-1:0] d_pc;
  logic [XLEN-1:0] d_pc_pls4;
  logic            d_ready;

  modport master (
    output f_valid, f_pc, flush, imem_gnt, imem_rvalid, imem_rdata, d_ready,
    input  f_ready, imem_req, imem_addr, d_valid, d_inst, d_pc, d_pc_pls4
  );

  modport slave (
    input  f_valid, f_pc, flush, imem_gnt, imem_rvalid, imem_rdata, d_ready,
    output f_ready, imem_req, imem_addr, d_valid, d_inst, d_pc, d_pc_pls4
  );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer. Fetch addresses are issued to instruction memory
// and allocated a slot in a circular buffer at grant time; in-order responses
// fill the slots, and decode pops from the head. A flush empties the buffer
// and remembers how many in-flight responses must still be thrown away.
module inst_fetch_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  inst_fetch_buffer_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0]   PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]   PTR_ZERO = {PW{1'b0}};
  localparam logic [PW:0]     DEPTH_W = (PW+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]   alloc_ptr_r;
  logic [PW-1:0]   fill_ptr_r;
  logic [PW-1:0]   read_ptr_r;
  logic [PW-1:0]   drop_cnt_r;
  logic [XLEN-1:0] pc_mem_r   [DEPTH];
  logic [31:0]     inst_mem_r [DEPTH];
  logic [DEPTH-1:0] filled_r;

  logic [IW-1:0]   alloc_idx_s;
  logic [IW-1:0]   fill_idx_s;
  logic [IW-1:0]   read_idx_s;
  logic [PW-1:0]   used_s;
  logic [PW-1:0]   outstanding_s;
  logic [PW:0]     occupancy_s;
  logic [PW-1:0]   resp_dec_s;
  logic            req_s;
  logic            grant_s;
  logic            drop_any_s;
  logic            resp_drop_s;
  logic            resp_fill_s;
  logic            d_valid_s;
  logic            pop_s;

  assign alloc_idx_s   = alloc_ptr_r[IW-1:0];
  assign fill_idx_s    = fill_ptr_r[IW-1:0];
  assign read_idx_s    = read_ptr_r[IW-1:0];
  assign used_s        = alloc_ptr_r - read_ptr_r;
  assign outstanding_s = alloc_ptr_r - fill_ptr_r;
  // Slots owed to flushed responses still count against capacity.
  assign occupancy_s   = {1'b0, used_s} + {1'b0, drop_cnt_r};

  assign req_s      = bus.f_valid & ~bus.flush & (occupancy_s < DEPTH_W);
  assign grant_s    = req_s & bus.imem_gnt;
  assign drop_any_s = (drop_cnt_r != PTR_ZERO);
  // A response with nothing owed and nothing outstanding is a protocol
  // violation and is ignored.
  assign resp_drop_s = bus.imem_rvalid & drop_any_s;
  assign resp_fill_s = bus.imem_rvalid & ~drop_any_s & (outstanding_s != PTR_ZERO);
  assign resp_dec_s  = (resp_drop_s | resp_fill_s) ? PTR_ONE : PTR_ZERO;

  assign d_valid_s = (read_ptr_r != fill_ptr_r) & filled_r[read_idx_s];
  assign pop_s     = d_valid_s & bus.d_ready;

  assign bus.imem_req  = req_s;
  assign bus.f_ready   = grant_s;
  assign bus.imem_addr = {bus.f_pc[XLEN-1:2], 2'b00};
  assign bus.d_valid   = d_valid_s;
  assign bus.d_inst    = inst_mem_r[read_idx_s];
  assign bus.d_pc      = pc_mem_r[read_idx_s];
  assign bus.d_pc_pls4 = pc_mem_r[read_idx_s] + PC_STEP;

  // Pointer, drop counter and entry storage updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_ptr_r <= PTR_ZERO;
      fill_ptr_r  <= PTR_ZERO;
      read_ptr_r  <= PTR_ZERO;
      drop_cnt_r  <= PTR_ZERO;
      filled_r    <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]   <= {XLEN{1'b0}};
        inst_mem_r[i] <= 32'h0000_0000;
      end
    end else if (bus.flush) begin
      // Everything in flight becomes a response to discard; a response
      // arriving this very cycle already settles one of them.
      alloc_ptr_r <= read_ptr_r;
      fill_ptr_r  <= read_ptr_r;
      drop_cnt_r  <= drop_cnt_r + outstanding_s - resp_dec_s;
    end else begin
      if (grant_s) begin
        pc_mem_r[alloc_idx_s] <= bus.f_pc;
        filled_r[alloc_idx_s] <= 1'b0;
        alloc_ptr_r           <= alloc_ptr_r + PTR_ONE;
      end
      if (resp_drop_s) begin
        drop_cnt_r <= drop_cnt_r - PTR_ONE;
      end else if (resp_fill_s) begin
        inst_mem_r[fill_idx_s] <= bus.imem_rdata;
        filled_r[fill_idx_s]   <= 1'b1;
        fill_ptr_r             <= fill_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        read_ptr_r <= read_ptr_r + PTR_ONE;
      end
    end
  end
endmodule
